// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_arbiter.
// slave is the arbiter's view; master is the pipeline/memory side that drives the requests.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_data_o;
  logic              if_ack_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;

  logic              stall_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_rdata_i,
    output if_data_o, if_ack_o,
    output dm_rdata_o, dm_ack_o,
    output stall_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_rdata_i,
    input  if_data_o, if_ack_o,
    input  dm_rdata_o, dm_ack_o,
    input  stall_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the IF and MEM stages, with a global pipeline stall.
// Each access runs IDLE -> BUSY (WAIT_CYC cycles) -> RESP (one-cycle ack).
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int              CNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              gnt_dm_q, gnt_dm_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              if_set, dm_set;
  logic              stall;

  // A done flag masks its requester until the pipeline advances.
  assign stall = (bus.if_req_i & ~if_done_q) | (bus.dm_req_i & ~dm_done_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_dm_d   = gnt_dm_q;
    mem_en_d   = mem_en_q;
    mem_we_d   = mem_we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_data_d  = if_data_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    if_set     = 1'b0;
    dm_set     = 1'b0;

    case (state_q)
      IDLE: begin
        // MEM stage holds the older instruction, so it wins ties.
        if (bus.dm_req_i && !dm_done_q) begin
          gnt_dm_d = 1'b1;
          mem_en_d = 1'b1;
          mem_we_d = bus.dm_we_i;
          addr_d   = bus.dm_addr_i;
          wdata_d  = bus.dm_wdata_i;
          cnt_d    = CNT_LOAD;
          state_d  = BUSY;
        end else if (bus.if_req_i && !if_done_q) begin
          gnt_dm_d = 1'b0;
          mem_en_d = 1'b1;
          mem_we_d = 1'b0;
          addr_d   = bus.if_addr_i;
          cnt_d    = CNT_LOAD;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (gnt_dm_q) begin
            dm_set   = 1'b1;
            dm_ack_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = bus.mem_rdata_i;
            end
          end else begin
            if_set    = 1'b1;
            if_ack_d  = 1'b1;
            if_data_d = bus.mem_rdata_i;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flags clear on any edge where the pipeline advances.
    if_done_d = stall ? (if_done_q | if_set) : 1'b0;
    dm_done_d = stall ? (dm_done_q | dm_set) : 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      gnt_dm_q   <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      gnt_dm_q   <= gnt_dm_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.mem_en_o    = mem_en_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.if_data_o   = if_data_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.dm_ack_o    = dm_ack_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance A uses WAIT_CYC=2, instance B uses WAIT_CYC=1.
// Stimulus pushes expected acks into per-instance queues; negedge monitors pop and compare.
module tb_mem_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    bit          is_dm;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a_if ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b_if ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(2)) u_a (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (a_if)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(1)) u_b (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (b_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0010: mem_model = 32'hDEAD_BEEF;
      32'h0000_0020: mem_model = 32'hCAFE_0020;
      32'h0000_0100: mem_model = 32'h0BAD_0100;
      default:       mem_model = {a[15:0] ^ 16'hBEEF, a[15:0]};
    endcase
  endfunction

  always_comb a_if.mem_rdata_i = mem_model(a_if.mem_addr_o);
  always_comb b_if.mem_rdata_i = mem_model(b_if.mem_addr_o);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitors
  always @(negedge clk) begin
    exp_t e;
    if (a_if.if_ack_o || a_if.dm_ack_o) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_ack cyc=%0d actual if_ack=%0b dm_ack=%0b required none",
                 cyc, a_if.if_ack_o, a_if.dm_ack_o);
      end else begin
        e = qa.pop_front();
        $display("A ack %s cyc=%0d data=%08h", a_if.dm_ack_o ? "DM" : "IF", cyc,
                 a_if.dm_ack_o ? a_if.dm_rdata_o : a_if.if_data_o);
        chk("a_ack_kind", {63'd0, a_if.dm_ack_o}, {63'd0, e.is_dm});
        chk("a_ack_both", {63'd0, a_if.dm_ack_o & a_if.if_ack_o}, 64'd0);
        chk("a_ack_cycle", 64'(cyc), 64'(e.cyc));
        chk("a_ack_data", {32'd0, e.is_dm ? a_if.dm_rdata_o : a_if.if_data_o}, {32'd0, e.data});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_if.if_ack_o || b_if.dm_ack_o) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_ack cyc=%0d actual if_ack=%0b dm_ack=%0b required none",
                 cyc, b_if.if_ack_o, b_if.dm_ack_o);
      end else begin
        e = qb.pop_front();
        $display("B ack %s cyc=%0d data=%08h", b_if.dm_ack_o ? "DM" : "IF", cyc,
                 b_if.dm_ack_o ? b_if.dm_rdata_o : b_if.if_data_o);
        chk("b_ack_kind", {63'd0, b_if.dm_ack_o}, {63'd0, e.is_dm});
        chk("b_ack_cycle", 64'(cyc), 64'(e.cyc));
        chk("b_ack_data", {32'd0, e.is_dm ? b_if.dm_rdata_o : b_if.if_data_o}, {32'd0, e.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int acc;
    logic en_prev;

    a_if.if_req_i = 0; a_if.if_addr_i = 0;
    a_if.dm_req_i = 0; a_if.dm_we_i = 0; a_if.dm_addr_i = 0; a_if.dm_wdata_i = 0;
    b_if.if_req_i = 0; b_if.if_addr_i = 0;
    b_if.dm_req_i = 0; b_if.dm_we_i = 0; b_if.dm_addr_i = 0; b_if.dm_wdata_i = 0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem_en", {63'd0, a_if.mem_en_o}, 64'd0);
    chk("rst_mem_we", {63'd0, a_if.mem_we_o}, 64'd0);
    chk("rst_mem_addr", {32'd0, a_if.mem_addr_o}, 64'd0);
    chk("rst_mem_wdata", {32'd0, a_if.mem_wdata_o}, 64'd0);
    chk("rst_if_data", {32'd0, a_if.if_data_o}, 64'd0);
    chk("rst_dm_rdata", {32'd0, a_if.dm_rdata_o}, 64'd0);
    chk("rst_acks", {62'd0, a_if.if_ack_o, a_if.dm_ack_o}, 64'd0);
    chk("rst_stall_idle", {63'd0, a_if.stall_o}, 64'd0);
    a_if.if_req_i = 1'b1;
    #1;
    chk("rst_stall_follows", {63'd0, a_if.stall_o}, 64'd1);
    a_if.if_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single IF fetch
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) tick();
      else begin
        tick();
        a_if.if_req_i = 1'b1; a_if.if_addr_i = 32'h10; c0 = cyc;
        qa.push_back('{1'b0, 32'hDEAD_BEEF, c0 + 3});
      end
      @(negedge clk);
      chk("t1_stall", {63'd0, a_if.stall_o}, {63'd0, k < 3});
      chk("t1_mem_en", {63'd0, a_if.mem_en_o}, {63'd0, k == 1 || k == 2});
      chk("t1_mem_we", {63'd0, a_if.mem_we_o}, 64'd0);
      if (k == 1 || k == 2) chk("t1_mem_addr", {32'd0, a_if.mem_addr_o}, 64'h10);
    end
    tick();
    a_if.if_req_i = 1'b0;

    // Simultaneous IF and DM read
    for (int k = 0; k <= 7; k++) begin
      tick();
      if (k == 0) begin
        a_if.if_req_i = 1'b1; a_if.if_addr_i = 32'h20;
        a_if.dm_req_i = 1'b1; a_if.dm_we_i = 1'b0; a_if.dm_addr_i = 32'h100;
        c0 = cyc;
        qa.push_back('{1'b1, 32'h0BAD_0100, c0 + 3});
        qa.push_back('{1'b0, 32'hCAFE_0020, c0 + 7});
      end
      @(negedge clk);
      chk("t2_stall", {63'd0, a_if.stall_o}, {63'd0, k < 7});
      chk("t2_mem_en", {63'd0, a_if.mem_en_o}, {63'd0, k == 1 || k == 2 || k == 5 || k == 6});
      if (k == 1 || k == 2) chk("t2_addr_dm", {32'd0, a_if.mem_addr_o}, 64'h100);
      if (k == 5 || k == 6) chk("t2_addr_if", {32'd0, a_if.mem_addr_o}, 64'h20);
      if (k >= 4) chk("t2_dm_hold", {32'd0, a_if.dm_rdata_o}, 64'h0BAD_0100);
    end
    tick();
    a_if.if_req_i = 1'b0; a_if.dm_req_i = 1'b0;

    // DM write
    for (int k = 0; k <= 3; k++) begin
      tick();
      if (k == 0) begin
        a_if.dm_req_i = 1'b1; a_if.dm_we_i = 1'b1;
        a_if.dm_addr_i = 32'h40; a_if.dm_wdata_i = 32'h1234_5678;
        c0 = cyc;
        qa.push_back('{1'b1, 32'h0BAD_0100, c0 + 3});
      end
      @(negedge clk);
      chk("t3_mem_en", {63'd0, a_if.mem_en_o}, {63'd0, k == 1 || k == 2});
      chk("t3_mem_we", {63'd0, a_if.mem_we_o}, {63'd0, k == 1 || k == 2});
      if (k == 1 || k == 2) begin
        chk("t3_mem_wdata", {32'd0, a_if.mem_wdata_o}, 64'h1234_5678);
        chk("t3_mem_addr", {32'd0, a_if.mem_addr_o}, 64'h40);
      end
    end
    tick();
    a_if.dm_req_i = 1'b0; a_if.dm_we_i = 1'b0;

    // No re-grant of IF inside one pipeline cycle
    acc = 0;
    en_prev = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      tick();
      if (k == 0) begin
        a_if.if_req_i = 1'b1; a_if.if_addr_i = 32'h50; c0 = cyc;
        qa.push_back('{1'b0, 32'hBEBF_0050, c0 + 3});
      end
      if (k == 1) begin
        a_if.dm_req_i = 1'b1; a_if.dm_we_i = 1'b0; a_if.dm_addr_i = 32'h60;
        qa.push_back('{1'b1, 32'hBE8F_0060, c0 + 7});
      end
      if (k == 8) begin
        a_if.dm_req_i = 1'b0; a_if.if_addr_i = 32'h54;
        qa.push_back('{1'b0, 32'hBEBB_0054, c0 + 11});
      end
      @(negedge clk);
      if (a_if.mem_en_o && !en_prev) acc++;
      en_prev = a_if.mem_en_o;
      chk("t4_stall", {63'd0, a_if.stall_o}, {63'd0, k < 7 || (k >= 8 && k < 11)});
      chk("t4_mem_en", {63'd0, a_if.mem_en_o},
          {63'd0, k == 1 || k == 2 || k == 5 || k == 6 || k == 9 || k == 10});
      if (k == 7) chk("t4_two_accesses", 64'(acc), 64'd2);
    end
    tick();
    a_if.if_req_i = 1'b0;

    // Reset in the middle of BUSY
    tick();
    a_if.if_req_i = 1'b1; a_if.if_addr_i = 32'h30;
    tick();
    @(negedge clk);
    chk("t5_busy", {63'd0, a_if.mem_en_o}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_mem_en", {63'd0, a_if.mem_en_o}, 64'd0);
    chk("t5_mem_addr", {32'd0, a_if.mem_addr_o}, 64'd0);
    chk("t5_if_data", {32'd0, a_if.if_data_o}, 64'd0);
    chk("t5_dm_rdata", {32'd0, a_if.dm_rdata_o}, 64'd0);
    chk("t5_acks", {62'd0, a_if.if_ack_o, a_if.dm_ack_o}, 64'd0);
    chk("t5_stall_req", {63'd0, a_if.stall_o}, 64'd1);
    a_if.if_req_i = 1'b0;
    #1;
    chk("t5_stall_noreq", {63'd0, a_if.stall_o}, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_quiet_en", {63'd0, a_if.mem_en_o}, 64'd0);
    end
    for (int k = 0; k <= 3; k++) begin
      tick();
      if (k == 0) begin
        a_if.if_req_i = 1'b1; a_if.if_addr_i = 32'h10; c0 = cyc;
        qa.push_back('{1'b0, 32'hDEAD_BEEF, c0 + 3});
      end
      @(negedge clk);
      chk("t5_restart_en", {63'd0, a_if.mem_en_o}, {63'd0, k == 1 || k == 2});
    end
    tick();
    a_if.if_req_i = 1'b0;

    // WAIT_CYC=1 back-to-back fetches
    for (int k = 0; k <= 9; k++) begin
      tick();
      if (k == 0) begin
        b_if.if_req_i = 1'b1; b_if.if_addr_i = 32'h0; c0 = cyc;
        qb.push_back('{1'b0, 32'hBEEF_0000, c0 + 2});
      end
      if (k == 3) begin
        b_if.if_addr_i = 32'h4;
        qb.push_back('{1'b0, 32'hBEEB_0004, c0 + 5});
      end
      if (k == 6) begin
        b_if.if_addr_i = 32'h8;
        qb.push_back('{1'b0, 32'hBEE7_0008, c0 + 8});
      end
      if (k == 9) b_if.if_req_i = 1'b0;
      @(negedge clk);
      chk("t6_mem_en", {63'd0, b_if.mem_en_o}, {63'd0, k == 1 || k == 4 || k == 7});
      chk("t6_stall", {63'd0, b_if.stall_o}, {63'd0, k < 9 && k != 2 && k != 5 && k != 8});
      if (k == 1 || k == 4 || k == 7) chk("t6_addr", {32'd0, b_if.mem_addr_o}, 64'((k / 3) * 4));
    end

    repeat (4) tick();
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
